// File: rtl/wbus_ram_slave.sv
// W-bus word-addressed RAM slave with programmable wait states and a single-cycle ack.
// Optional misaligned-access error reporting on W_ERR when WBUS_SLV_ERR_EN is defined.
module wbus_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_STATES = 1
) (
  input  logic        W_CLK,
  input  logic        W_RST,
  input  logic        W_STB,
  input  logic [31:0] W_ADDR,
  input  logic        W_WRITE,
  input  logic [31:0] W_DATA_I,
  output logic [31:0] W_DATA_O,
  output logic        W_ACK
`ifdef WBUS_SLV_ERR_EN
  ,
  output logic        W_ERR
`endif
);

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_DONE} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         data_q;
  logic                wr_q;
  logic                mis_q;
  logic                hit;
  logic                misaligned;
  logic                fire;
  logic [31:0]         mem [0:(1<<ADDR_W)-1];

  assign hit = (W_ADDR[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);

`ifdef WBUS_SLV_ERR_EN
  assign misaligned = |W_ADDR[1:0];
`else
  // Byte offset carries no meaning without error reporting; folded away here.
  assign misaligned = 1'b0 & (|W_ADDR[1:0]);
`endif

  // The access happens on the edge that enters ACK; the counter gives WAIT_STATES+1 edges of latency.
  assign fire = (state == S_WAIT) && W_STB && (cnt == 4'd0);

  always_ff @(posedge W_CLK) begin
    if (fire && wr_q && !mis_q && !W_RST)
      mem[idx_q] <= data_q;
  end

  always_ff @(posedge W_CLK or posedge W_RST) begin
    if (W_RST) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      idx_q    <= '0;
      data_q   <= 32'h0;
      wr_q     <= 1'b0;
      mis_q    <= 1'b0;
      W_ACK    <= 1'b0;
      W_DATA_O <= 32'h0;
`ifdef WBUS_SLV_ERR_EN
      W_ERR    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (W_STB && hit) begin
            idx_q  <= W_ADDR[ADDR_W+1:2];
            data_q <= W_DATA_I;
            wr_q   <= W_WRITE;
            mis_q  <= misaligned;
            cnt    <= WS_INIT;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!W_STB) begin
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            state <= S_ACK;
            W_ACK <= 1'b1;
            if (mis_q)
              W_DATA_O <= 32'hDEAD_BEEF;
            else if (!wr_q)
              W_DATA_O <= mem[idx_q];
`ifdef WBUS_SLV_ERR_EN
            W_ERR <= mis_q;
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACK: begin
          W_ACK <= 1'b0;
`ifdef WBUS_SLV_ERR_EN
          W_ERR <= 1'b0;
`endif
          // An initiator that drops strobe right after the ack may restart immediately.
          state <= W_STB ? S_DONE : S_IDLE;
        end
        S_DONE: begin
          if (!W_STB)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wbus_ram_slave.sv
// Randomized and directed bench for wbus_ram_slave: three instances with different
// base/wait settings, checked against an array-based memory model.
module tb_wbus_ram_slave;

  localparam int N = 3;
  localparam logic [31:0] BASE [N] = '{32'h0000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam int          WS   [N] = '{1, 3, 0};
`ifdef WBUS_SLV_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb  [N];
  logic [31:0] addr [N];
  logic        wr   [N];
  logic [31:0] wdat [N];
  logic [31:0] rdat [N];
  logic        ack  [N];
  logic        err  [N];

  logic [31:0] mem_m   [N][1024];
  bit          known   [N][1024];
  logic [31:0] last_rd [N];
  bit          last_ok [N];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wbus_ram_slave #(.BASE_ADDR(32'h0000_0000), .ADDR_W(10), .WAIT_STATES(1)) u_dut0 (
    .W_CLK(clk), .W_RST(rst), .W_STB(stb[0]), .W_ADDR(addr[0]), .W_WRITE(wr[0]),
    .W_DATA_I(wdat[0]), .W_DATA_O(rdat[0]), .W_ACK(ack[0])
`ifdef WBUS_SLV_ERR_EN
    , .W_ERR(err[0])
`endif
  );
  wbus_ram_slave #(.BASE_ADDR(32'h1000_0000), .ADDR_W(10), .WAIT_STATES(3)) u_dut1 (
    .W_CLK(clk), .W_RST(rst), .W_STB(stb[1]), .W_ADDR(addr[1]), .W_WRITE(wr[1]),
    .W_DATA_I(wdat[1]), .W_DATA_O(rdat[1]), .W_ACK(ack[1])
`ifdef WBUS_SLV_ERR_EN
    , .W_ERR(err[1])
`endif
  );
  wbus_ram_slave #(.BASE_ADDR(32'h0000_0000), .ADDR_W(10), .WAIT_STATES(0)) u_dut2 (
    .W_CLK(clk), .W_RST(rst), .W_STB(stb[2]), .W_ADDR(addr[2]), .W_WRITE(wr[2]),
    .W_DATA_I(wdat[2]), .W_DATA_O(rdat[2]), .W_ACK(ack[2])
`ifdef WBUS_SLV_ERR_EN
    , .W_ERR(err[2])
`endif
  );
`ifndef WBUS_SLV_ERR_EN
  assign err[0] = 1'b0;
  assign err[1] = 1'b0;
  assign err[2] = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One complete transaction; hold = extra cycles strobe stays high after the ack.
  task automatic xfer(input int u, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input int hold);
    int  k;
    int  idx;
    bit  hit_m;
    bit  mis_m;
    hit_m = (a >> 12) == (BASE[u] >> 12);
    idx   = int'(a[11:2]);
    mis_m = ERR_BUILD && (a[1:0] != 2'b00);
    stb[u] = 1'b1; addr[u] = a; wr[u] = w; wdat[u] = d;
    k = 0;
    for (int i = 1; i <= WS[u] + 6; i++) begin
      tick();
      if (ack[u]) begin
        k = i;
        break;
      end
    end
    if (!hit_m) begin
      check("miss_no_ack", k, 0);
    end else begin
      check("ack_latency", k, WS[u] + 2);
      if (k != 0) begin
        if (mis_m) begin
          last_rd[u] = 32'hDEAD_BEEF;
          last_ok[u] = 1'b1;
        end else if (w) begin
          mem_m[u][idx] = d;
          known[u][idx] = 1'b1;
        end else begin
          last_rd[u] = mem_m[u][idx];
          last_ok[u] = known[u][idx];
        end
        if (last_ok[u]) check(w ? "rdata_held" : "rdata", rdat[u], last_rd[u]);
`ifdef WBUS_SLV_ERR_EN
        check("err_flag", err[u], mis_m);
`endif
      end
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      check("single_ack", ack[u], 0);
    end
    stb[u] = 1'b0;
    tick();
    check("ack_low", ack[u], 0);
  endtask

  // Write that is abandoned after 'drop' edges; no ack and no write may follow.
  task automatic abort_write(input int u, input logic [31:0] a, input logic [31:0] d,
                             input int drop);
    int acks;
    acks = 0;
    stb[u] = 1'b1; addr[u] = a; wr[u] = 1'b1; wdat[u] = d;
    for (int i = 0; i < drop; i++) begin
      tick();
      if (ack[u]) acks++;
    end
    stb[u] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack[u]) acks++;
    end
    check("abort_no_ack", acks, 0);
  endtask

  initial begin
    for (int u = 0; u < N; u++) begin
      stb[u] = 1'b0; addr[u] = 32'h0; wr[u] = 1'b0; wdat[u] = 32'h0;
      last_rd[u] = 32'h0; last_ok[u] = 1'b1;
      for (int j = 0; j < 1024; j++) begin
        known[u][j] = 1'b0;
        mem_m[u][j] = 32'h0;
      end
    end
    tick();
    tick();
    for (int u = 0; u < N; u++) begin
      check("reset_ack", ack[u], 0);
      check("reset_data", rdat[u], 32'h0);
    end
    rst = 1'b0;
    tick();

    xfer(0, 1'b1, 32'h0000_0010, 32'h1234_5678, 0);
    xfer(0, 1'b0, 32'h0000_0010, 32'h0, 0);
    xfer(0, 1'b1, 32'h0000_0000, 32'hCAFE_0001, 10);
    xfer(0, 1'b0, 32'h0000_0000, 32'h0, 0);
    xfer(0, 1'b1, 32'h0000_0004, 32'h1111_1111, 0);
    xfer(0, 1'b1, 32'h0000_0006, 32'h2222_2222, 0);
    xfer(0, 1'b0, 32'h0000_0004, 32'h0, 0);

    xfer(1, 1'b0, 32'h2000_0000, 32'h0, 11);
    xfer(1, 1'b1, 32'h1000_0040, 32'h0BAD_F00D, 0);
    abort_write(1, 32'h1000_0040, 32'hAAAA_AAAA, 2);
    xfer(1, 1'b0, 32'h1000_0040, 32'h0, 0);

    xfer(2, 1'b1, 32'h0000_0FFC, 32'hFEED_F00D, 0);
    xfer(2, 1'b0, 32'h0000_0FFC, 32'h0, 0);

    // Reset mid-WAIT: the pending write is dropped and outputs clear at once.
    xfer(0, 1'b1, 32'h0000_0020, 32'h5555_5555, 0);
    xfer(0, 1'b0, 32'h0000_0020, 32'h0, 0);
    stb[0] = 1'b1; addr[0] = 32'h0000_0020; wr[0] = 1'b1; wdat[0] = 32'h9999_9999;
    tick();
    rst = 1'b1;
    #1;
    check("rst_mid_ack", ack[0], 0);
    check("rst_mid_data", rdat[0], 32'h0);
    for (int u = 0; u < N; u++) begin
      last_rd[u] = 32'h0;
      last_ok[u] = 1'b1;
    end
    @(negedge clk);
    stb[0] = 1'b0;
    rst = 1'b0;
    begin
      int acks;
      acks = 0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (ack[0]) acks++;
      end
      check("rst_no_ack", acks, 0);
    end
    xfer(0, 1'b0, 32'h0000_0020, 32'h0, 0);

    for (int t = 0; t < 80; t++) begin
      int          u;
      int          r;
      logic [31:0] a;
      u = int'($urandom_range(0, N - 1));
      r = int'($urandom_range(0, 15));
      a = BASE[u] | (32'((r < 8) ? r : 1016 + r) << 2) | 32'($urandom_range(0, 3));
      if (u == 1 && $urandom_range(0, 7) == 0) a = 32'h0000_0100;
      xfer(u, 1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
